// File: rtl/svec_vme_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// svec_vme_pkg: shared constants and types for the SVEC VME slave front end
// Rev 1.0
//------------------------------------------------------------------------------
package svec_vme_pkg;

   localparam logic [5:0]  c_AM_CSR      = 6'h2F;
   localparam logic [5:0]  c_AM_A24_USER = 6'h39;
   localparam logic [5:0]  c_AM_A24_SUP  = 6'h3D;

   localparam logic [18:0] c_CR_ID_C     = 19'h0001F;
   localparam logic [18:0] c_CR_ID_R     = 19'h00023;
   localparam logic [18:0] c_CSR_WB32    = 19'h7FF33;
   localparam logic [18:0] c_CSR_BIT_CLR = 19'h7FFF7;
   localparam logic [18:0] c_CSR_BIT_SET = 19'h7FFFB;
   localparam logic [18:0] c_CSR_BAR     = 19'h7FFFF;
   localparam logic [14:0] c_CSR_ADER0_PG = 15'h7FF6;
   localparam logic [14:0] c_CSR_ADER1_PG = 15'h7FF7;
   localparam int          c_EN_BIT      = 4;

   localparam logic [31:0] c_SDB_ID       = 32'h5344422D;
   localparam logic [21:0] c_OFS_SDB      = 22'h020000;
   localparam logic [21:0] c_OFS_OW       = 22'h030000;
   localparam logic [21:0] c_OFS_IE       = 22'h031084;
   localparam logic [21:0] c_OFS_TDC_CFG  = 22'h0310A0;
   localparam logic [21:0] c_OFS_STATUS   = 22'h0310F8;
   localparam logic [21:0] c_OFS_TDC_CTRL = 22'h0310FC;
   localparam logic [11:0] c_RAM_PAGE     = 12'h0D0;

   typedef logic [2:0] vme_state_t;
   localparam vme_state_t c_ST_IDLE     = 3'd0;
   localparam vme_state_t c_ST_DECODE   = 3'd1;
   localparam vme_state_t c_ST_ACCESS   = 3'd2;
   localparam vme_state_t c_ST_DTACK    = 3'd3;
   localparam vme_state_t c_ST_WAIT_END = 3'd4;

   typedef enum logic [1:0] {SEL_NONE, SEL_CSR, SEL_USER} vme_sel_e;

   // ADER bytes are stored MSB first at increasing offsets
   function automatic logic [7:0] ader_byte(input logic [31:0] ader, input logic [1:0] idx);
      case (idx)
         2'd0:    return ader[31:24];
         2'd1:    return ader[23:16];
         2'd2:    return ader[15:8];
         default: return ader[7:0];
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/vme_csr_regs.sv
`default_nettype none
//------------------------------------------------------------------------------
// vme_csr_regs: CR ROM, CSR registers and function-1 ADER address decode
// Rev 1.0
//------------------------------------------------------------------------------
module vme_csr_regs
   import svec_vme_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic [4:0]  slot_i,
   input  logic        we_i,
   input  logic [18:0] offset_i,
   input  logic [7:0]  wdata_i,
   output logic [7:0]  rdata_o,
   input  logic [5:0]  am_i,
   input  logic [1:0]  addr_hi_i,
   output logic        func1_hit_o
);

   logic [31:0] ader0_q;
   logic [31:0] ader1_q;
   logic        wb32_q;
   logic        enable_q;

   logic        w_ader0_sel;
   logic        w_ader1_sel;
   logic [1:0]  w_byte_idx;

   assign w_ader0_sel = (offset_i[18:4] == c_CSR_ADER0_PG) && (offset_i[1:0] == 2'b11);
   assign w_ader1_sel = (offset_i[18:4] == c_CSR_ADER1_PG) && (offset_i[1:0] == 2'b11);
   assign w_byte_idx  = offset_i[3:2];

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         ader0_q  <= '0;
         ader1_q  <= '0;
         wb32_q   <= 1'b0;
         enable_q <= 1'b0;
      end else if (we_i) begin
         if (w_ader0_sel) begin
            case (w_byte_idx)
               2'd0:    ader0_q[31:24] <= wdata_i;
               2'd1:    ader0_q[23:16] <= wdata_i;
               2'd2:    ader0_q[15:8]  <= wdata_i;
               default: ader0_q[7:0]   <= wdata_i;
            endcase
         end
         if (w_ader1_sel) begin
            case (w_byte_idx)
               2'd0:    ader1_q[31:24] <= wdata_i;
               2'd1:    ader1_q[23:16] <= wdata_i;
               2'd2:    ader1_q[15:8]  <= wdata_i;
               default: ader1_q[7:0]   <= wdata_i;
            endcase
         end
         if (offset_i == c_CSR_WB32)
            wb32_q <= wdata_i[0];
         if ((offset_i == c_CSR_BIT_SET) && wdata_i[c_EN_BIT])
            enable_q <= 1'b1;
         if ((offset_i == c_CSR_BIT_CLR) && wdata_i[c_EN_BIT])
            enable_q <= 1'b0;
      end
   end

   always_comb begin
      rdata_o = 8'h00;
      if (w_ader0_sel)
         rdata_o = ader_byte(ader0_q, w_byte_idx);
      else if (w_ader1_sel)
         rdata_o = ader_byte(ader1_q, w_byte_idx);
      else if (offset_i == c_CSR_WB32)
         rdata_o = {7'b0, wb32_q};
      else if (offset_i == c_CSR_BIT_SET)
         rdata_o = {3'b0, enable_q, 4'b0};
      else if (offset_i == c_CSR_BAR)
         rdata_o = {slot_i, 3'b000};
      else if (offset_i == c_CR_ID_C)
         rdata_o = 8'h43;
      else if (offset_i == c_CR_ID_R)
         rdata_o = 8'h52;
   end

   // Function 0 is never decoded; a set XAM bit or a zero AM field disables function 1
   assign func1_hit_o = enable_q && !ader1_q[0] && (ader1_q[7:2] != 6'h00) &&
                        (am_i == ader1_q[7:2]) && (addr_hi_i == ader1_q[23:22]);

endmodule
`default_nettype wire

// File: rtl/svec_vme_top.sv
`default_nettype none
//------------------------------------------------------------------------------
// svec_vme_top: VME64x slave (CR/CSR + one A24/D32 function) over a small map
// Rev 1.0
//------------------------------------------------------------------------------
module svec_vme_top
   import svec_vme_pkg::*;
#(
   parameter int g_simulation  = 0,
   parameter int g_with_wr_phy = 0
)(
   input  logic        clk_125m_pllref_p_i,
   input  logic        rst_n_a_i,
   input  logic        vme_as_n_i,
   input  logic [1:0]  vme_ds_n_i,
   input  logic        vme_write_n_i,
   input  logic [5:0]  vme_am_i,
   inout  wire  [30:0] vme_addr_b,
   inout  wire         vme_lword_n_b,
   inout  wire  [31:0] vme_data_b,
   input  logic [4:0]  vme_ga_i,
   input  logic        vme_gap_i,
   input  logic        vme_iackin_n_i,
   output logic        vme_iackout_n_o,
   output logic        vme_dtack_n_o,
   output logic        vme_dtack_oe_o,
   output logic        vme_berr_o,
   output logic        vme_retry_n_o,
   output logic        vme_retry_oe_o,
   output logic        vme_data_dir_o,
   output logic        vme_data_oe_n_o,
   output logic        vme_addr_dir_o,
   output logic        vme_addr_oe_n_o,
   output logic [6:0]  vme_irq_o,
   input  logic        fmc0_tdc_pll_status_i
);

   logic        clk;
   logic        rst_n;
   assign clk   = clk_125m_pllref_p_i;
   assign rst_n = rst_n_a_i;

   logic        as_meta_q, as_sync_q, wr_meta_q, wr_sync_q;
   logic [1:0]  ds_meta_q, ds_sync_q;
   vme_state_t  state_q;
   vme_sel_e    sel_q;
   logic [23:1] addr_q;
   logic [5:0]  am_q;
   logic        lword_n_q, write_q, acc_wait_q;
   logic [31:0] wdata_q, rdata_q;
   logic        dtack_n_q, dtack_oe_q, drive_q;
   logic [31:0] ow_q, ie_q, tdc_cfg_q, tdc_ctrl_q;
   logic [31:0] ram_q [0:255];
   logic [31:0] ram_rdata_q;

   logic [4:0]  w_slot;
   logic [18:0] w_csr_ofs;
   logic [21:0] w_user_ofs;
   logic        w_ram_sel;
   logic [7:0]  w_ram_idx;
   logic        w_func1_hit, w_csr_match, w_user_match;
   logic        w_access_we, w_csr_we, w_user_we;
   logic [7:0]  w_csr_rdata;
   logic [31:0] w_user_rdata;
   logic        w_unused;

   assign w_slot     = ~vme_ga_i;
   assign w_csr_ofs  = {addr_q[18:1], 1'b1};
   assign w_user_ofs = {addr_q[21:1], 1'b0};
   assign w_ram_sel  = (w_user_ofs[21:10] == c_RAM_PAGE);
   assign w_ram_idx  = addr_q[9:2];

   assign w_csr_match  = (am_q == c_AM_CSR) && (addr_q[23:19] == w_slot) &&
                         (ds_sync_q == 2'b10) && lword_n_q;
   assign w_user_match = w_func1_hit && ((am_q == c_AM_A24_USER) || (am_q == c_AM_A24_SUP)) &&
                         (ds_sync_q == 2'b00) && !lword_n_q && !addr_q[1];

   // Writes land on the first ACCESS cycle only, so the RAM wait cycle never repeats them
   assign w_access_we = (state_q == c_ST_ACCESS) && !acc_wait_q && write_q;
   assign w_csr_we    = w_access_we && (sel_q == SEL_CSR);
   assign w_user_we   = w_access_we && (sel_q == SEL_USER);

   vme_csr_regs u_csr (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .slot_i      (w_slot),
      .we_i        (w_csr_we),
      .offset_i    (w_csr_ofs),
      .wdata_i     (wdata_q[7:0]),
      .rdata_o     (w_csr_rdata),
      .am_i        (am_q),
      .addr_hi_i   (addr_q[23:22]),
      .func1_hit_o (w_func1_hit)
   );

   always_comb begin
      w_user_rdata = 32'h0;
      if (w_ram_sel)
         w_user_rdata = ram_rdata_q;
      else begin
         case (w_user_ofs)
            c_OFS_SDB:      w_user_rdata = c_SDB_ID;
            c_OFS_OW:       w_user_rdata = ow_q;
            c_OFS_IE:       w_user_rdata = ie_q;
            c_OFS_TDC_CFG:  w_user_rdata = tdc_cfg_q;
            c_OFS_TDC_CTRL: w_user_rdata = tdc_ctrl_q;
            c_OFS_STATUS:   w_user_rdata = {31'b0, fmc0_tdc_pll_status_i};
            default:        w_user_rdata = 32'h0;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         as_meta_q  <= 1'b1;
         as_sync_q  <= 1'b1;
         ds_meta_q  <= 2'b11;
         ds_sync_q  <= 2'b11;
         wr_meta_q  <= 1'b1;
         wr_sync_q  <= 1'b1;
         state_q    <= c_ST_IDLE;
         sel_q      <= SEL_NONE;
         addr_q     <= '0;
         am_q       <= '0;
         lword_n_q  <= 1'b1;
         write_q    <= 1'b0;
         acc_wait_q <= 1'b0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         dtack_n_q  <= 1'b1;
         dtack_oe_q <= 1'b0;
         drive_q    <= 1'b0;
      end else begin
         as_meta_q <= vme_as_n_i;
         as_sync_q <= as_meta_q;
         ds_meta_q <= vme_ds_n_i;
         ds_sync_q <= ds_meta_q;
         wr_meta_q <= vme_write_n_i;
         wr_sync_q <= wr_meta_q;
         if (as_sync_q) begin
            state_q    <= c_ST_IDLE;
            acc_wait_q <= 1'b0;
            dtack_n_q  <= 1'b1;
            dtack_oe_q <= 1'b0;
            drive_q    <= 1'b0;
         end else begin
            case (state_q)
               c_ST_IDLE: begin
                  addr_q    <= vme_addr_b[22:0];
                  am_q      <= vme_am_i;
                  lword_n_q <= vme_lword_n_b;
                  state_q   <= c_ST_DECODE;
               end
               c_ST_DECODE: begin
                  if (ds_sync_q != 2'b11) begin
                     write_q <= ~wr_sync_q;
                     wdata_q <= vme_data_b;
                     if (w_csr_match) begin
                        sel_q   <= SEL_CSR;
                        state_q <= c_ST_ACCESS;
                     end else if (w_user_match) begin
                        sel_q   <= SEL_USER;
                        state_q <= c_ST_ACCESS;
                     end else begin
                        // Not ours: sit out the cycle silently, master times out
                        sel_q   <= SEL_NONE;
                        state_q <= c_ST_WAIT_END;
                     end
                  end
               end
               c_ST_ACCESS: begin
                  if ((sel_q == SEL_USER) && w_ram_sel && !acc_wait_q)
                     acc_wait_q <= 1'b1;
                  else begin
                     acc_wait_q <= 1'b0;
                     rdata_q    <= (sel_q == SEL_CSR) ? {24'h0, w_csr_rdata} : w_user_rdata;
                     drive_q    <= ~write_q;
                     dtack_oe_q <= 1'b1;
                     state_q    <= c_ST_DTACK;
                  end
               end
               c_ST_DTACK: begin
                  dtack_n_q <= 1'b0;
                  state_q   <= c_ST_WAIT_END;
               end
               c_ST_WAIT_END: begin
                  if (ds_sync_q == 2'b11) begin
                     dtack_n_q  <= 1'b1;
                     dtack_oe_q <= 1'b0;
                     drive_q    <= 1'b0;
                     state_q    <= c_ST_IDLE;
                  end
               end
               default: state_q <= c_ST_IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ow_q       <= '0;
         ie_q       <= '0;
         tdc_cfg_q  <= '0;
         tdc_ctrl_q <= '0;
      end else if (w_user_we && !w_ram_sel) begin
         case (w_user_ofs)
            c_OFS_OW:       ow_q       <= wdata_q;
            c_OFS_IE:       ie_q       <= wdata_q;
            c_OFS_TDC_CFG:  tdc_cfg_q  <= wdata_q;
            c_OFS_TDC_CTRL: tdc_ctrl_q <= wdata_q;
            default:        ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (w_user_we && w_ram_sel)
         ram_q[w_ram_idx] <= wdata_q;
      ram_rdata_q <= ram_q[w_ram_idx];
   end

   assign vme_data_b      = drive_q ? rdata_q : 32'bz;
   assign vme_addr_b      = 31'bz;
   assign vme_lword_n_b   = 1'bz;
   assign vme_dtack_n_o   = dtack_n_q;
   assign vme_dtack_oe_o  = dtack_oe_q;
   assign vme_data_dir_o  = drive_q;
   assign vme_data_oe_n_o = 1'b0;
   assign vme_addr_dir_o  = 1'b0;
   assign vme_addr_oe_n_o = 1'b0;
   assign vme_berr_o      = 1'b0;
   assign vme_retry_n_o   = 1'b1;
   assign vme_retry_oe_o  = 1'b0;
   assign vme_irq_o       = 7'b0;
   assign vme_iackout_n_o = vme_iackin_n_i;

   assign w_unused = ^{vme_gap_i, vme_addr_b[30:23], (g_simulation != 0), (g_with_wr_phy != 0)};

endmodule
`default_nettype wire

// File: tb/tb_svec_vme_top.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_svec_vme_top: directed VME master exercising CR/CSR and the A24/D32 map
// Rev 1.0
//------------------------------------------------------------------------------
module tb_svec_vme_top;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        as_n = 1'b1;
   logic [1:0]  ds_n = 2'b11;
   logic        write_n = 1'b1;
   logic [5:0]  am = 6'h00;
   logic [30:0] addr_r = '0;
   logic        lword_r = 1'b1;
   logic [31:0] data_r = '0;
   logic        addr_oe = 1'b0;
   logic        data_oe = 1'b0;
   logic        iackin_n = 1'b1;
   logic        pll_status = 1'b0;

   wire  [30:0] vme_addr_w;
   wire         vme_lword_w;
   wire  [31:0] vme_data_w;
   assign vme_addr_w  = addr_oe ? addr_r  : 31'bz;
   assign vme_lword_w = addr_oe ? lword_r : 1'bz;
   assign vme_data_w  = data_oe ? data_r  : 32'bz;

   logic       iackout_n, dtack_n, dtack_oe, berr, retry_n, retry_oe;
   logic       data_dir, data_oe_n, addr_dir, addr_oe_n;
   logic [6:0] irq;

   int checks = 0;
   int errors = 0;

   svec_vme_top #(.g_simulation(0), .g_with_wr_phy(0)) dut (
      .clk_125m_pllref_p_i   (clk),
      .rst_n_a_i             (rst_n),
      .vme_as_n_i            (as_n),
      .vme_ds_n_i            (ds_n),
      .vme_write_n_i         (write_n),
      .vme_am_i              (am),
      .vme_addr_b            (vme_addr_w),
      .vme_lword_n_b         (vme_lword_w),
      .vme_data_b            (vme_data_w),
      .vme_ga_i              (5'b10111),
      .vme_gap_i             (1'b0),
      .vme_iackin_n_i        (iackin_n),
      .vme_iackout_n_o       (iackout_n),
      .vme_dtack_n_o         (dtack_n),
      .vme_dtack_oe_o        (dtack_oe),
      .vme_berr_o            (berr),
      .vme_retry_n_o         (retry_n),
      .vme_retry_oe_o        (retry_oe),
      .vme_data_dir_o        (data_dir),
      .vme_data_oe_n_o       (data_oe_n),
      .vme_addr_dir_o        (addr_dir),
      .vme_addr_oe_n_o       (addr_oe_n),
      .vme_irq_o             (irq),
      .fmc0_tdc_pll_status_i (pll_status)
   );

   always #4 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // One full master cycle; waits up to 125 clk (1 us) for DTACK
   task automatic vme_cycle(input logic [5:0] m, input logic [23:0] a, input bit wr, input bit d32,
                            input logic [31:0] wd, output logic [31:0] rd, output bit acked,
                            output int lat);
      bit rel;
      int n;
      @(negedge clk);
      am      = m;
      addr_r  = {8'h00, a[23:1]};
      lword_r = ~d32;
      write_n = ~wr;
      data_r  = d32 ? wd : {24'h0, wd[7:0]};
      addr_oe = 1'b1;
      data_oe = wr;
      repeat (2) @(negedge clk);
      as_n = 1'b0;
      repeat (2) @(negedge clk);
      ds_n  = d32 ? 2'b00 : 2'b10;
      acked = 1'b0;
      lat   = 0;
      rd    = '0;
      while (!acked && lat < 125) begin
         @(negedge clk);
         lat++;
         if (dtack_n === 1'b0) acked = 1'b1;
      end
      if (acked) rd = d32 ? vme_data_w : {24'h0, vme_data_w[7:0]};
      ds_n = 2'b11;
      if (acked) begin
         rel = 1'b0;
         n   = 0;
         while (!rel && n < 6) begin
            @(negedge clk);
            n++;
            if (dtack_n === 1'b1 && dtack_oe === 1'b0 && data_dir === 1'b0) rel = 1'b1;
         end
         check("dtack_release", {31'b0, rel}, 32'd1);
      end
      as_n    = 1'b1;
      addr_oe = 1'b0;
      data_oe = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   logic [31:0] rd;
   bit          ack;
   int          lat;
   localparam logic [23:0] CSR = 24'h400000;

   initial begin
      repeat (5) @(negedge clk);
      check("rst_dtack_n", {31'b0, dtack_n}, 32'd1);
      check("rst_dtack_oe", {31'b0, dtack_oe}, 32'd0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_bufctl", {28'b0, data_dir, data_oe_n, addr_dir, addr_oe_n}, 32'd0);
      check("fixed_outs", {23'b0, berr, retry_n, retry_oe, irq}, {23'b0, 1'b0, 1'b1, 1'b0, 7'b0});
      iackin_n = 1'b0; #1;
      check("iack_low", {31'b0, iackout_n}, 32'd0);
      iackin_n = 1'b1; #1;
      check("iack_high", {31'b0, iackout_n}, 32'd1);

      vme_cycle(6'h2F, CSR | 24'h7FFFF, 1'b0, 1'b0, 0, rd, ack, lat);
      check("bar_ack", {31'b0, ack}, 32'd1);
      check("bar_read", rd, 32'h40);
      vme_cycle(6'h2F, CSR | 24'h0001F, 1'b0, 1'b0, 0, rd, ack, lat);
      check("cr_c", rd, 32'h43);
      vme_cycle(6'h2F, CSR | 24'h00023, 1'b0, 1'b0, 0, rd, ack, lat);
      check("cr_r", rd, 32'h52);
      vme_cycle(6'h2F, 24'h480000 | 24'h7FFFF, 1'b0, 1'b0, 0, rd, ack, lat);
      check("csr_wrong_slot_noack", {31'b0, ack}, 32'd0);

      vme_cycle(6'h2F, CSR | 24'h7FF73, 1'b1, 1'b0, 32'h00, rd, ack, lat);
      check("ader1_b3_ack", {31'b0, ack}, 32'd1);
      vme_cycle(6'h2F, CSR | 24'h7FF77, 1'b1, 1'b0, 32'hC0, rd, ack, lat);
      vme_cycle(6'h2F, CSR | 24'h7FF7B, 1'b1, 1'b0, 32'h00, rd, ack, lat);
      vme_cycle(6'h2F, CSR | 24'h7FF7F, 1'b1, 1'b0, 32'hE4, rd, ack, lat);
      vme_cycle(6'h2F, CSR | 24'h7FF77, 1'b0, 1'b0, 0, rd, ack, lat);
      check("ader1_b2_rb", rd, 32'hC0);
      vme_cycle(6'h2F, CSR | 24'h7FF7F, 1'b0, 1'b0, 0, rd, ack, lat);
      check("ader1_b0_rb", rd, 32'hE4);

      vme_cycle(6'h39, 24'hC20000, 1'b0, 1'b1, 0, rd, ack, lat);
      check("disabled_noack", {31'b0, ack}, 32'd0);
      vme_cycle(6'h2F, CSR | 24'h7FFFB, 1'b1, 1'b0, 32'h10, rd, ack, lat);
      vme_cycle(6'h2F, CSR | 24'h7FFFB, 1'b0, 1'b0, 0, rd, ack, lat);
      check("bit_set_status", rd, 32'h10);

      vme_cycle(6'h39, 24'hC20000, 1'b0, 1'b1, 0, rd, ack, lat);
      check("sdb_ack", {31'b0, ack}, 32'd1);
      check("sdb_read", rd, 32'h5344422D);

      vme_cycle(6'h39, 24'hC34000, 1'b1, 1'b1, 32'd1234, rd, ack, lat);
      vme_cycle(6'h39, 24'hC34004, 1'b1, 1'b1, 32'd5678, rd, ack, lat);
      vme_cycle(6'h39, 24'hC34000, 1'b0, 1'b1, 0, rd, ack, lat);
      check("ram0_read", rd, 32'h4D2);
      check("ram_latency", {31'b0, (lat <= 11)}, 32'd1);
      vme_cycle(6'h39, 24'hC34004, 1'b0, 1'b1, 0, rd, ack, lat);
      check("ram1_read", rd, 32'h162E);

      vme_cycle(6'h39, 24'hC31084, 1'b0, 1'b1, 0, rd, ack, lat);
      check("ie_reset", rd, 32'h0);
      vme_cycle(6'h39, 24'hC310FC, 1'b1, 1'b1, 32'h200, rd, ack, lat);
      vme_cycle(6'h39, 24'hC310FC, 1'b0, 1'b1, 0, rd, ack, lat);
      check("tdc_ctrl_rb", rd, 32'h200);
      vme_cycle(6'h39, 24'hC30000, 1'b0, 1'b1, 0, rd, ack, lat);
      check("ow_reset", rd, 32'h0);
      pll_status = 1'b1;
      vme_cycle(6'h39, 24'hC310F8, 1'b0, 1'b1, 0, rd, ack, lat);
      check("status_pll", rd, 32'h1);
      vme_cycle(6'h39, 24'hC00100, 1'b0, 1'b1, 0, rd, ack, lat);
      check("unmapped_ack", {31'b0, ack}, 32'd1);
      check("unmapped_zero", rd, 32'h0);

      vme_cycle(6'h3D, 24'hC20000, 1'b0, 1'b1, 0, rd, ack, lat);
      check("wrong_am_noack", {31'b0, ack}, 32'd0);
      vme_cycle(6'h39, 24'h820000, 1'b0, 1'b1, 0, rd, ack, lat);
      check("wrong_window_noack", {31'b0, ack}, 32'd0);
      vme_cycle(6'h39, 24'hC20000, 1'b0, 1'b0, 0, rd, ack, lat);
      check("d08_user_noack", {31'b0, ack}, 32'd0);

      vme_cycle(6'h2F, CSR | 24'h7FFF7, 1'b1, 1'b0, 32'h10, rd, ack, lat);
      vme_cycle(6'h39, 24'hC20000, 1'b0, 1'b1, 0, rd, ack, lat);
      check("bit_clr_noack", {31'b0, ack}, 32'd0);
      vme_cycle(6'h2F, CSR | 24'h7FFFB, 1'b1, 1'b0, 32'h10, rd, ack, lat);

      // Reset asserted while DTACK is low
      @(negedge clk);
      am = 6'h39; addr_r = {8'h00, 23'h610000}; lword_r = 1'b0; write_n = 1'b1; addr_oe = 1'b1;
      repeat (2) @(negedge clk);
      as_n = 1'b0;
      repeat (2) @(negedge clk);
      ds_n = 2'b00;
      ack = 1'b0;
      lat = 0;
      while (!ack && lat < 125) begin
         @(negedge clk);
         lat++;
         if (dtack_n === 1'b0) ack = 1'b1;
      end
      check("midrst_dtack_seen", {31'b0, ack}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst_release", {29'b0, dtack_n, dtack_oe, data_dir}, {29'b0, 1'b1, 1'b0, 1'b0});
      @(negedge clk);
      ds_n = 2'b11; as_n = 1'b1; addr_oe = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      vme_cycle(6'h39, 24'hC20000, 1'b0, 1'b1, 0, rd, ack, lat);
      check("post_rst_noack", {31'b0, ack}, 32'd0);
      vme_cycle(6'h2F, CSR | 24'h7FF7F, 1'b0, 1'b0, 0, rd, ack, lat);
      check("post_rst_ader1", rd, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
